// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: parses one SPI transaction (opcode, start address,
// data bytes) into 32-bit register-write strobes with an auto-incrementing
// word address. Bytes come from spi_slave; spi_ss is the raw, asynchronous
// slave select and is synchronised here.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame open; bytes ignored, waiting for an armed ss falling edge
// CMD     | expecting the opcode byte
// ADDR    | expecting the start-address byte
// DATA    | packing data bytes MSB-first into words, one write per 4 bytes
// DISCARD | bad opcode seen; swallow bytes until ss rises
module spi_frame_decoder #(
  parameter logic [7:0] WR_OPCODE   = 8'hA5,
  parameter int         ADDR_W      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_ss,
  input  logic              data_en_i,
  input  logic [7:0]        data_i,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    DATA    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  ss_sync;
  // Tracks which synchroniser stages hold a real pin sample rather than the
  // reset value, so the reset preload of 1 can never arm a frame start while
  // spi_ss is actually low.
  logic [SYNC_STAGES-1:0]  ss_vld;
  logic                    ss_s;
  logic                    ss_q;
  logic                    armed;
  logic                    err;
  logic [1:0]              byte_cnt;
  logic [ADDR_W-1:0]       addr_cnt;
  logic [31:0]             word;
  logic [31:0]             word_next;
  logic                    ss_fall;
  logic                    ss_rise;
  logic                    end_bad;

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign ss_fall   = armed & ss_q & ~ss_s;
  assign ss_rise   = ~ss_q & ss_s;
  assign word_next = {word[23:0], data_i};

  // Frame-end verdict, taking into account a byte accepted in the same cycle.
  always_comb begin
    end_bad = err;
    case (state)
      CMD:     end_bad = 1'b1;
      ADDR:    end_bad = err | ~data_en_i;
      DATA:    end_bad = err | (data_en_i ? (byte_cnt != 2'd3) : (byte_cnt != 2'd0));
      DISCARD: end_bad = 1'b1;
      default: end_bad = err;
    endcase
  end

  // Synchroniser, edge detect, frame FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ss_sync    <= '1;
      ss_vld     <= '0;
      ss_q       <= 1'b1;
      armed      <= 1'b0;
      state      <= IDLE;
      err        <= 1'b0;
      byte_cnt   <= 2'd0;
      addr_cnt   <= '0;
      word       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      ss_vld     <= {ss_vld[SYNC_STAGES-2:0], 1'b1};
      ss_q       <= ss_s;
      if (ss_s && ss_vld[SYNC_STAGES-1]) armed <= 1'b1;

      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (ss_fall) begin
            state    <= CMD;
            busy     <= 1'b1;
            err      <= 1'b0;
            byte_cnt <= 2'd0;
          end
        end
        CMD: begin
          if (data_en_i) begin
            if (data_i == WR_OPCODE) begin
              state <= ADDR;
            end else begin
              state <= DISCARD;
              err   <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (data_en_i) begin
            addr_cnt <= ADDR_W'(data_i);
            byte_cnt <= 2'd0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (data_en_i) begin
            word <= word_next;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= word_next;
              wr_addr  <= addr_cnt;
              addr_cnt <= addr_cnt + ADDR_W'(1);
              byte_cnt <= 2'd0;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        DISCARD: ;
        default: state <= IDLE;
      endcase

      // Closing the frame overrides the state update above; busy stays high
      // through the frame_done cycle and is cleared from IDLE next cycle.
      if (ss_rise && state != IDLE) begin
        state      <= IDLE;
        frame_done <= 1'b1;
        frame_err  <= end_bad;
        byte_cnt   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Testbench for spi_frame_decoder: table of whole frames with expected
// writes and verdicts, a scoreboard fed when stimulus is driven and drained
// by a monitor, plus hand sequences for the coincident-end and reset cases.
module tb_spi_frame_decoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        spi_ss = 1'b1;
  logic        data_en_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        busy;

  spi_frame_decoder dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_ss     (spi_ss),
    .data_en_i  (data_en_i),
    .data_i     (data_i),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // b: frame bytes, first byte in [127:120]; a: expected write addresses,
  // first in [31:24]; w: expected words, first in [127:96].
  typedef struct {
    logic [127:0] b;
    int           n;
    int           nw;
    logic [31:0]  a;
    logic [127:0] w;
    logic         err;
  } vec_t;

  vec_t        vecs[8];
  logic [39:0] wr_q[$];
  logic        done_q[$];
  logic [39:0] mon_exp;
  logic        mon_err;
  int          checks = 0;
  int          passes = 0;
  int          n_wr = 0;
  int          n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    data_en_i = 1'b1;
    data_i    = b;
    ticks(1);
    data_en_i = 1'b0;
    ticks(gap);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 30 && (done_q.size() != 0 || wr_q.size() != 0); k++) ticks(1);
    if (done_q.size() != 0 || wr_q.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: pending writes=%0d frames=%0d expected 0", name, wr_q.size(), done_q.size());
      wr_q.delete();
      done_q.delete();
    end
  endtask

  task automatic run_frame(input vec_t v, input int gap);
    for (int k = 0; k < v.nw; k++)
      wr_q.push_back({v.a[31-8*k -: 8], v.w[127-32*k -: 32]});
    done_q.push_back(v.err);
    spi_ss = 1'b0;
    ticks(5);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < v.n; i++) send_byte(v.b[127-8*i -: 8], gap);
    ticks(2);
    spi_ss = 1'b1;
    wait_drain("frame");
    ticks(3);
    check("busy_after_frame", busy, 0);
  endtask

  // Scoreboard drain: every write and every frame end must be expected.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_wr++;
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_wr: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_exp = wr_q.pop_front();
        check("wr_addr", wr_addr, mon_exp[39:32]);
        check("wr_data", wr_data, mon_exp[31:0]);
      end
    end
    if (frame_done === 1'b1) begin
      n_done++;
      if (done_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got frame_done err=%0b expected none", frame_err);
      end else begin
        mon_err = done_q.pop_front();
        check("frame_err", frame_err, mon_err);
      end
    end else if (frame_err === 1'b1) begin
      checks++;
      $display("FAIL err_without_done: got frame_err=1 expected 0");
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr0;
    int done0;

    vecs[0] = '{b: {48'hA5_10_12345678, 80'h0}, n: 6, nw: 1,
                a: {8'h10, 24'h0}, w: {32'h12345678, 96'h0}, err: 1'b0};
    vecs[1] = '{b: {112'hA5_FE_11223344_55667788_99AABBCC, 16'h0}, n: 14, nw: 3,
                a: {24'hFE_FF_00, 8'h0}, w: {96'h11223344_55667788_99AABBCC, 32'h0}, err: 1'b0};
    vecs[2] = '{b: {48'h3C_10_12345678, 80'h0}, n: 6, nw: 0,
                a: 32'h0, w: 128'h0, err: 1'b1};
    vecs[3] = '{b: {56'hA5_20_AABBCCDD_EE, 72'h0}, n: 7, nw: 1,
                a: {8'h20, 24'h0}, w: {32'hAABBCCDD, 96'h0}, err: 1'b1};
    vecs[4] = '{b: {8'hA5, 120'h0}, n: 1, nw: 0, a: 32'h0, w: 128'h0, err: 1'b1};
    vecs[5] = '{b: {16'hA5_30, 112'h0}, n: 2, nw: 0, a: 32'h0, w: 128'h0, err: 1'b0};
    vecs[6] = '{b: 128'h0, n: 0, nw: 0, a: 32'h0, w: 128'h0, err: 1'b1};
    vecs[7] = '{b: {80'hA5_40_DEADBEEF_01020304, 48'h0}, n: 10, nw: 2,
                a: {16'h40_41, 16'h0}, w: {64'hDEADBEEF_01020304, 64'h0}, err: 1'b0};

    ticks(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rstn = 1'b1;
    ticks(6);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i % 2);

    // Last data byte lands in the same cycle the synced ss rising edge is seen.
    wr_q.push_back({8'h50, 32'hC0FFEE11});
    done_q.push_back(1'b0);
    spi_ss = 1'b0;
    ticks(5);
    send_byte(8'hA5, 0);
    send_byte(8'h50, 0);
    data_en_i = 1'b1;
    data_i    = 8'hC0;
    ticks(1);
    data_i    = 8'hFF;
    spi_ss    = 1'b1;
    ticks(1);
    data_i    = 8'hEE;
    ticks(1);
    data_i    = 8'h11;
    ticks(1);
    data_en_i = 1'b0;
    check("coinc_wr_en", wr_en, 1);
    check("coinc_frame_done", frame_done, 1);
    check("coinc_frame_err", frame_err, 0);
    wait_drain("coinc");
    ticks(4);

    // Reset in the middle of a word with ss held low.
    spi_ss = 1'b0;
    ticks(5);
    send_byte(8'hA5, 0);
    send_byte(8'h60, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rstn = 1'b0;
    ticks(2);
    rstn = 1'b1;
    check("rst_mid_busy", busy, 0);
    wr0   = n_wr;
    done0 = n_done;
    for (int i = 0; i < 8; i++) send_byte(8'h33 + 8'(i * 17), 0);
    ticks(3);
    spi_ss = 1'b1;
    ticks(10);
    check("rst_mid_no_wr", n_wr, wr0);
    check("rst_mid_no_done", n_done, done0);
    check("rst_mid_busy_idle", busy, 0);
    run_frame(vecs[0], 0);
    run_frame(vecs[1], 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
- Downstream consumer of spi_slave: takes its byte stream (data_en_o/data_o) plus the raw SPI slave-select and parses each SPI transaction into a write-command frame.
- Frame format: opcode byte, start-address byte, then data bytes. Data is packed MSB-first into 32-bit words.
- Each completed word is emitted as a single-cycle register-write strobe with an auto-incrementing address.
- Sits between spi_slave and the on-chip register file / bus bridge, all in the clk domain.

Parameters:
- WR_OPCODE, 8'hA5, the only accepted opcode (write burst).
- ADDR_W, 8, width of the word address. The address byte is zero-extended or truncated to ADDR_W.
- SYNC_STAGES, 2, number of synchroniser flops on spi_ss (minimum 2).

Ports:
- clk  in  1  system clock, same clock as spi_slave.clk.
- rstn  in  1  synchronous, active-low reset.
- spi_ss  in  1  raw SPI slave select, active low, asynchronous to clk.
- data_en_i  in  1  byte-valid strobe from spi_slave data_en_o, one cycle per byte.
- data_i  in  8  received byte from spi_slave data_o.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_W  word address for the current write.
- wr_data  out  32  assembled word; first received byte lands in [31:24].
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the frame was bad.
- busy  out  1  high while in CMD, ADDR, DATA or DISCARD.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - All outputs go to 0 and state goes to IDLE.
  - Synchroniser flops are set to 1; armed flag, byte counter and address counter are cleared.
- spi_ss passes through SYNC_STAGES flops to give ss_s.
  - armed is set when ss_s=1 is observed.
  - Frame start = ss_s falling edge with armed=1.
  - Frame end = ss_s rising edge.
  - A reset during a low spi_ss therefore never starts a frame mid-transaction.
- IDLE:
  - data_en_i is ignored.
  - On frame start, go to CMD.
- CMD:
  - On a byte equal to WR_OPCODE, go to ADDR.
  - On any other byte, go to DISCARD and latch err=1.
- ADDR: on a byte, load the address counter with data_i and go to DATA.
- DATA:
  - Each byte shifts into a 32-bit register (word = {word[23:0], data_i}) and increments a 2-bit byte counter.
  - When the 4th byte arrives, the next cycle drives wr_en=1, wr_data=word and wr_addr=address counter. The address counter then increments, wrapping modulo 2^ADDR_W with no error. The byte counter returns to 0.
  - Latency is 1 clk from the data_en_i of the 4th byte to wr_en.
  - Back-to-back data_en_i on consecutive cycles must be accepted with no loss.
- DISCARD: bytes are ignored until frame end.
- Frame end in any state other than IDLE:
  - Next cycle: frame_done=1 and state goes to IDLE.
  - frame_err=1 in that same cycle if any of the following hold:
    - err was latched;
    - the frame ended in CMD or ADDR;
    - the frame ended in DATA with byte counter ≠ 0. A partial word is discarded and wr_en is not asserted for it.
  - An empty frame ending in DATA with 0 words is not an error.
- Simultaneous data_en_i and frame end in the same cycle:
  - The byte is processed first, then the frame is closed.
  - If that byte completes a word, wr_en and frame_done assert in the same cycle.
- Frame start while not in IDLE cannot occur, because a rising edge must intervene.
- wr_addr and wr_data hold their last values when wr_en=0. Consumers sample only on wr_en.
- busy=1 from the cycle after frame start until the cycle frame_done is asserted, inclusive.
- Reset mid-frame:
  - Any partial word is dropped and no frame_done is issued.
  - The block waits for spi_ss to go high, then the next falling edge.

Test Plan:
- Frame A5,10,12,34,56,78 then ss_n high → exactly one wr_en with wr_addr=0x10, wr_data=0x12345678; then frame_done=1, frame_err=0.
- Frame A5,FE plus 12 data bytes (3 words) → wr_en at addresses 0xFE, 0xFF, 0x00 (wrap) with the correct words; frame_err=0.
- Frame 3C,10,12,34,56,78 → no wr_en; frame_done=1 and frame_err=1 at end.
- Frame A5,20,AA,BB,CC,DD,EE (partial 5th byte) → one wr_en (0x20, 0xAABBCCDD); frame_err=1 at end.
- Drive data_en_i on 4 consecutive clks with the last byte coincident with the synced ss_n rising edge → wr_en and frame_done in the same cycle, frame_err=0.
- Assert rstn=0 mid-DATA with ss_n still low, release it, then resume bytes → no wr_en or frame_done until ss_n goes high; the next complete frame decodes normally.
